// File: rtl/controlador_display.sv
// Time-multiplexed driver for a three-digit common-anode seven-segment display.
// Scans sign, tens and units in turn; segment and digit-select lines are active-low
// and registered so the pads see glitch-free transitions.
module controlador_display #(
  parameter int unsigned DIVISOR = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       atualizar,
  input  logic       habilitar,
  input  logic       sinal,
  input  logic [3:0] dezena,
  input  logic [3:0] unidade,
  output logic [6:0] seg,
  output logic [2:0] digito,
  output logic       quadro
);

  localparam int unsigned CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] ContMax = CW'(DIVISOR - 1);

  localparam logic [6:0] SegBlank = 7'h7F;
  localparam logic [6:0] SegMinus = 7'h3F;
  localparam logic [6:0] SegErr   = 7'h06;

  logic [CW-1:0] cont_q, cont_d;
  logic [1:0]    indice_q, indice_d;
  logic          s_q, s_d;
  logic [3:0]    d_q, d_d;
  logic [3:0]    u_q, u_d;
  logic [6:0]    seg_q, seg_d;
  logic [2:0]    digito_q, digito_d;
  logic          quadro_q, quadro_d;
  logic          slot_end;

  // Digit glyph lookup for valid BCD values; anything above 9 shows 'E'.
  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'd0:    g = 7'h40;
      4'd1:    g = 7'h79;
      4'd2:    g = 7'h24;
      4'd3:    g = 7'h30;
      4'd4:    g = 7'h19;
      4'd5:    g = 7'h12;
      4'd6:    g = 7'h02;
      4'd7:    g = 7'h78;
      4'd8:    g = 7'h00;
      4'd9:    g = 7'h10;
      default: g = SegErr;
    endcase
    return g;
  endfunction

  // Capture, prescaler, slot index and frame pulse next-state.
  always_comb begin
    s_d      = s_q;
    d_d      = d_q;
    u_d      = u_q;
    cont_d   = cont_q + CW'(1);
    indice_d = indice_q;
    slot_end = (cont_q == ContMax);
    if (atualizar) begin
      s_d = sinal;
      d_d = dezena;
      u_d = unidade;
    end
    if (slot_end) begin
      cont_d   = '0;
      indice_d = (indice_q == 2'd2) ? 2'd0 : indice_q + 2'd1;
    end
    quadro_d = slot_end && (indice_q == 2'd2);
  end

  // Output pattern decoded from the current slot and the captured registers only.
  always_comb begin
    seg_d    = SegBlank;
    digito_d = 3'b111;
    if (habilitar) begin
      unique case (indice_q)
        2'd0: begin
          digito_d = 3'b011;
          seg_d    = s_q ? SegMinus : SegBlank;
        end
        2'd1: begin
          digito_d = 3'b101;
          seg_d    = (d_q == 4'd0) ? SegBlank : glyph(d_q);
        end
        2'd2: begin
          digito_d = 3'b110;
          seg_d    = glyph(u_q);
        end
        default: begin
          digito_d = 3'b111;
          seg_d    = SegBlank;
        end
      endcase
    end
  end

  // State registers; synchronous reset wins over capture and prescaler advance.
  always_ff @(posedge clock) begin
    if (reset) begin
      cont_q   <= '0;
      indice_q <= 2'd0;
      s_q      <= 1'b0;
      d_q      <= 4'd0;
      u_q      <= 4'd0;
      seg_q    <= SegBlank;
      digito_q <= 3'b111;
      quadro_q <= 1'b0;
    end else begin
      cont_q   <= cont_d;
      indice_q <= indice_d;
      s_q      <= s_d;
      d_q      <= d_d;
      u_q      <= u_d;
      seg_q    <= seg_d;
      digito_q <= digito_d;
      quadro_q <= quadro_d;
    end
  end

  assign seg    = seg_q;
  assign digito = digito_q;
  assign quadro = quadro_q;

endmodule

// File: tb/tb_controlador_display.sv
// Directed bench for controlador_display with DIVISOR=4.
// n counts rising edges since the first reset release; with no intervening reset,
// edge k shows slot ((k-1)/4)%3 and quadro is high after edges that are multiples of 12.
module tb_controlador_display;

  logic       clock = 1'b0;
  logic       reset;
  logic       atualizar;
  logic       habilitar;
  logic       sinal;
  logic [3:0] dezena;
  logic [3:0] unidade;
  logic [6:0] seg;
  logic [2:0] digito;
  logic       quadro;

  int vecs = 0;
  int errs = 0;
  int n    = 0;

  controlador_display #(
    .DIVISOR(4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .atualizar(atualizar),
    .habilitar(habilitar),
    .sinal    (sinal),
    .dezena   (dezena),
    .unidade  (unidade),
    .seg      (seg),
    .digito   (digito),
    .quadro   (quadro)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
    n++;
  endtask

  task automatic goto(input int target);
    while (n < target) tick();
  endtask

  task automatic check(input string tag, input logic [6:0] es, input logic [2:0] ed,
                       input logic eq);
    vecs++;
    assert (seg === es) else begin
      errs++;
      $error("FAIL %s seg=%h expected %h (edge %0d)", tag, seg, es, n);
    end
    vecs++;
    assert (digito === ed) else begin
      errs++;
      $error("FAIL %s digito=%b expected %b (edge %0d)", tag, digito, ed, n);
    end
    vecs++;
    assert (quadro === eq) else begin
      errs++;
      $error("FAIL %s quadro=%b expected %b (edge %0d)", tag, quadro, eq, n);
    end
  endtask

  initial begin
    // Reset held with an update request and non-zero data: reset must win.
    reset     = 1'b1;
    atualizar = 1'b1;
    habilitar = 1'b1;
    sinal     = 1'b1;
    dezena    = 4'd4;
    unidade   = 4'd7;
    tick();
    tick();
    n = 0;
    check("reset", 7'h7F, 3'b111, 1'b0);
    reset     = 1'b0;
    atualizar = 1'b0;

    // 1: idle scan of zero data.
    goto(1);  check("s1_sign_first", 7'h7F, 3'b011, 1'b0);
    goto(4);  check("s1_sign_last",  7'h7F, 3'b011, 1'b0);
    goto(5);  check("s1_tens_blank", 7'h7F, 3'b101, 1'b0);
    goto(9);  check("s1_units_zero", 7'h40, 3'b110, 1'b0);
    goto(11); check("s1_pre_frame",  7'h40, 3'b110, 1'b0);
    goto(12); check("s1_frame",      7'h40, 3'b110, 1'b1);
    goto(13); check("s1_frame_end",  7'h7F, 3'b011, 1'b0);

    // 2: capture -47, then change inputs without capture.
    sinal = 1'b1; dezena = 4'd4; unidade = 4'd7; atualizar = 1'b1;
    goto(14);
    atualizar = 1'b0;
    sinal = 1'b0; dezena = 4'd9; unidade = 4'd9;
    goto(15); check("s2_minus",      7'h3F, 3'b011, 1'b0);
    goto(17); check("s2_tens4",      7'h19, 3'b101, 1'b0);
    goto(21); check("s2_units7",     7'h78, 3'b110, 1'b0);
    goto(23); check("s2_pre_frame",  7'h78, 3'b110, 1'b0);
    goto(24); check("s2_frame",      7'h78, 3'b110, 1'b1);
    goto(25); check("s2_hold_minus", 7'h3F, 3'b011, 1'b0);

    // 3: +05 blanks sign and tens, then invalid tens shows E.
    sinal = 1'b0; dezena = 4'd0; unidade = 4'd5; atualizar = 1'b1;
    goto(26);
    atualizar = 1'b0;
    goto(27); check("s3_sign_blank", 7'h7F, 3'b011, 1'b0);
    goto(29); check("s3_tens_blank", 7'h7F, 3'b101, 1'b0);
    goto(33); check("s3_units5",     7'h12, 3'b110, 1'b0);
    goto(36); check("s3_frame",      7'h12, 3'b110, 1'b1);
    dezena = 4'd12; atualizar = 1'b1;
    goto(37);
    atualizar = 1'b0;
    check("s3_sign_after", 7'h7F, 3'b011, 1'b0);
    goto(41); check("s3_tens_err",   7'h06, 3'b101, 1'b0);

    // 4: update on the same edge the index moves from sign to tens.
    goto(51);
    sinal = 1'b1; dezena = 4'd3; unidade = 4'd8; atualizar = 1'b1;
    goto(52);
    atualizar = 1'b0;
    check("s4_old_sign",   7'h7F, 3'b011, 1'b0);
    goto(53); check("s4_tens3_first", 7'h30, 3'b101, 1'b0);
    goto(57); check("s4_units8",     7'h00, 3'b110, 1'b0);
    goto(60); check("s4_frame",      7'h00, 3'b110, 1'b1);
    goto(61); check("s4_minus",      7'h3F, 3'b011, 1'b0);

    // 5: display disabled for 5 edges mid tens slot.
    goto(66); check("s5_before",     7'h30, 3'b101, 1'b0);
    habilitar = 1'b0;
    goto(67); check("s5_off_first",  7'h7F, 3'b111, 1'b0);
    goto(70); check("s5_off_mid",    7'h7F, 3'b111, 1'b0);
    goto(71); check("s5_off_last",   7'h7F, 3'b111, 1'b0);
    habilitar = 1'b1;
    goto(72); check("s5_on_frame",   7'h00, 3'b110, 1'b1);
    goto(73); check("s5_on_sign",    7'h3F, 3'b011, 1'b0);

    // 6: reset in units slot while updating; captured data must clear.
    goto(82); check("s6_before",     7'h00, 3'b110, 1'b0);
    reset = 1'b1; atualizar = 1'b1; sinal = 1'b1; dezena = 4'd9; unidade = 4'd9;
    goto(83); check("s6_reset",      7'h7F, 3'b111, 1'b0);
    reset = 1'b0; atualizar = 1'b0;
    goto(84); check("s6_sign_first", 7'h7F, 3'b011, 1'b0);
    goto(87); check("s6_sign_last",  7'h7F, 3'b011, 1'b0);
    goto(88); check("s6_tens_blank", 7'h7F, 3'b101, 1'b0);
    goto(92); check("s6_units_zero", 7'h40, 3'b110, 1'b0);
    goto(95); check("s6_frame",      7'h40, 3'b110, 1'b1);
    goto(96); check("s6_wrap",       7'h7F, 3'b011, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
